// File: rtl/instr_seq.sv
// Instruction sequencer: fetches instruction words, decodes the class field and
// issues timed pulse, register-write and qclk-load strobes, with wait states for
// qclk time, sync and fproc handshakes.
// Optional late-pulse detection is enabled by defining INSTR_SEQ_LATE_CHECK_EN.
module instr_seq #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIME_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_rd_en,
  input  logic                  mem_rd_valid,
  input  logic [7:0]            opcode,
  input  logic [TIME_WIDTH-1:0] cmd_time,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic [TIME_WIDTH-1:0] qclk_val,
  input  logic                  alu_cond,
  input  logic                  sync_in,
  input  logic                  fproc_in,
  output logic [ADDR_WIDTH-1:0] instr_ptr,
  output logic                  c_strobe,
  output logic                  reg_write_en,
  output logic                  qclk_load_en,
  output logic                  sync_out_ready,
  output logic                  fproc_out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  late_err
);

`ifdef INSTR_SEQ_LATE_CHECK_EN
  localparam bit LATE_CHECK = 1'b1;
`else
  localparam bit LATE_CHECK = 1'b0;
`endif

  // Instruction class codes carried in opcode[7:3].
  localparam logic [4:0] CLS_REG_I_ALU   = 5'h01;
  localparam logic [4:0] CLS_REG_ALU     = 5'h02;
  localparam logic [4:0] CLS_REG_WRITE_I = 5'h03;
  localparam logic [4:0] CLS_JUMP_I      = 5'h04;
  localparam logic [4:0] CLS_JUMP_COND_I = 5'h05;
  localparam logic [4:0] CLS_INC_QCLK    = 5'h06;
  localparam logic [4:0] CLS_INC_QCLK_I  = 5'h07;
  localparam logic [4:0] CLS_PULSE_I     = 5'h08;
  localparam logic [4:0] CLS_WAIT_SYNC   = 5'h09;
  localparam logic [4:0] CLS_WAIT_FPROC  = 5'h0A;
  localparam logic [4:0] CLS_DONE        = 5'h0B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT_TIME,
    S_WAIT_SYNC,
    S_WAIT_FPROC,
    S_DONE
  } state_t;

  state_t                  state;
  logic [4:0]              cls_q;
  logic [TIME_WIDTH-1:0]   cmd_time_q;
  logic [ADDR_WIDTH-1:0]   jump_addr_q;
  logic                    late_err_q;

  logic [TIME_WIDTH-1:0]   time_diff;
  logic                    time_zero;
  logic                    time_late;
  logic                    time_future;
  logic                    time_hit;
  logic                    in_exec;
  logic                    advance;
  logic                    jump;

  // Only the class field steers execution; the low opcode bits are don't-care.
  logic                    unused_opcode_bits;
  assign unused_opcode_bits = ^opcode[2:0];

  // Signed distance to the command time, modulo the qclk width.
  assign time_diff   = cmd_time_q - qclk_val;
  assign time_zero   = (time_diff == '0);
  assign time_late   = time_diff[TIME_WIDTH-1];
  assign time_future = !time_zero && !time_late;
  assign time_hit    = (qclk_val == cmd_time_q);
  assign in_exec     = (state == S_EXEC);

  // Execute strobes are compared against the live qclk_val, so they are decoded
  // from the registered state and latched instruction rather than re-registered.
  assign c_strobe = (in_exec && cls_q == CLS_PULSE_I &&
                     (time_zero || (time_late && !LATE_CHECK))) ||
                    (state == S_WAIT_TIME && time_hit);

  assign reg_write_en = in_exec && (cls_q == CLS_REG_WRITE_I ||
                                    cls_q == CLS_REG_I_ALU   ||
                                    cls_q == CLS_REG_ALU);

  assign qclk_load_en = in_exec && (cls_q == CLS_INC_QCLK ||
                                    cls_q == CLS_INC_QCLK_I);

  assign late_err = late_err_q;

  // Decide whether this cycle ends an instruction by stepping or jumping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    advance = 1'b0;
    jump    = 1'b0;
    case (state)
      S_EXEC: begin
        case (cls_q)
          CLS_PULSE_I:     advance = !time_future;
          CLS_JUMP_I:      jump    = 1'b1;
          CLS_JUMP_COND_I: begin
            jump    = alu_cond;
            advance = !alu_cond;
          end
          CLS_WAIT_SYNC, CLS_WAIT_FPROC, CLS_DONE: ;
          default:         advance = 1'b1;
        endcase
      end
      S_WAIT_TIME:  advance = time_hit;
      S_WAIT_SYNC:  advance = sync_in;
      S_WAIT_FPROC: advance = fproc_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the latched instruction is reset too, so nothing from a prior run
      // can be executed after reset.
      state           <= S_IDLE;
      instr_ptr       <= '0;
      cls_q           <= '0;
      cmd_time_q      <= '0;
      jump_addr_q     <= '0;
      late_err_q      <= 1'b0;
      mem_rd_en       <= 1'b0;
      sync_out_ready  <= 1'b0;
      fproc_out_ready <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees
      // the pre-edge values regardless of statement order.
      mem_rd_en <= 1'b0;

      if (advance || jump) begin
        instr_ptr       <= jump ? jump_addr_q : instr_ptr + ADDR_WIDTH'(1);
        state           <= S_FETCH;
        mem_rd_en       <= 1'b1;
        sync_out_ready  <= 1'b0;
        fproc_out_ready <= 1'b0;
      end

      if (LATE_CHECK && in_exec && cls_q == CLS_PULSE_I && time_late)
        late_err_q <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            instr_ptr  <= '0;
            late_err_q <= 1'b0;
            state      <= S_FETCH;
            mem_rd_en  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_FETCH: begin
          if (mem_rd_valid) begin
            cls_q       <= opcode[7:3];
            cmd_time_q  <= cmd_time;
            jump_addr_q <= jump_addr;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Strobes seen during this cycle never satisfy the wait being entered.
          case (cls_q)
            CLS_PULSE_I:    if (time_future) state <= S_WAIT_TIME;
            CLS_WAIT_SYNC: begin
              state          <= S_WAIT_SYNC;
              sync_out_ready <= 1'b1;
            end
            CLS_WAIT_FPROC: begin
              state           <= S_WAIT_FPROC;
              fproc_out_ready <= 1'b1;
            end
            CLS_DONE: begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WAIT_TIME, S_WAIT_SYNC, S_WAIT_FPROC: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq.sv
// Self-checking bench for instr_seq: a behavioural instruction memory with
// programmable read latency, and a scoreboard of expected execute strobes.
module tb_instr_seq;

  localparam int AW = 8;
  localparam int TW = 32;

  localparam logic [4:0] C_NOP         = 5'h1E;
  localparam logic [4:0] C_REG_I_ALU   = 5'h01;
  localparam logic [4:0] C_REG_ALU     = 5'h02;
  localparam logic [4:0] C_REG_WRITE_I = 5'h03;
  localparam logic [4:0] C_JUMP_I      = 5'h04;
  localparam logic [4:0] C_JUMP_COND_I = 5'h05;
  localparam logic [4:0] C_INC_QCLK    = 5'h06;
  localparam logic [4:0] C_INC_QCLK_I  = 5'h07;
  localparam logic [4:0] C_PULSE_I     = 5'h08;
  localparam logic [4:0] C_WAIT_SYNC   = 5'h09;
  localparam logic [4:0] C_WAIT_FPROC  = 5'h0A;
  localparam logic [4:0] C_DONE        = 5'h0B;

`ifdef INSTR_SEQ_LATE_CHECK_EN
  localparam bit LATE_MODE = 1'b1;
`else
  localparam bit LATE_MODE = 1'b0;
`endif

  typedef struct {
    logic [4:0]    cls;
    logic [TW-1:0] t;
    logic [AW-1:0] j;
    logic          cond;
  } instr_t;

  typedef enum int {EV_STROBE, EV_REG, EV_QCLK} ev_kind_t;

  typedef struct {
    ev_kind_t      kind;
    bit            chk_time;
    logic [TW-1:0] qclk;
  } ev_t;

  logic          clk, reset, start;
  logic          mem_rd_en, mem_rd_valid;
  logic [7:0]    opcode;
  logic [TW-1:0] cmd_time, qclk_val;
  logic [AW-1:0] jump_addr, instr_ptr;
  logic          alu_cond, sync_in, fproc_in;
  logic          c_strobe, reg_write_en, qclk_load_en;
  logic          sync_out_ready, fproc_out_ready, busy, done, late_err;

  instr_t        mem [256];
  ev_t           sb [$];
  logic [AW-1:0] ptr_sb [$];
  int            checks = 0;
  int            failures = 0;
  int            lat = 1;
  bit            qclk_run = 1'b0;

  bit            mem_pend;
  int            mem_cnt;
  logic [AW-1:0] mem_addr;
  int            mon_n;
  ev_t           mon_e;
  ev_kind_t      mon_kind;

  instr_seq #(.ADDR_WIDTH(AW), .TIME_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_rd_valid(mem_rd_valid),
    .opcode(opcode), .cmd_time(cmd_time), .jump_addr(jump_addr),
    .qclk_val(qclk_val), .alu_cond(alu_cond),
    .sync_in(sync_in), .fproc_in(fproc_in),
    .instr_ptr(instr_ptr), .c_strobe(c_strobe), .reg_write_en(reg_write_en),
    .qclk_load_en(qclk_load_en), .sync_out_ready(sync_out_ready),
    .fproc_out_ready(fproc_out_ready), .busy(busy), .done(done),
    .late_err(late_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outs_vec();
    return {mem_rd_en, c_strobe, reg_write_en, qclk_load_en, sync_out_ready,
            fproc_out_ready, busy, done, late_err};
  endfunction

  task automatic present(input logic [AW-1:0] a);
    mem_rd_valid = 1'b1;
    opcode       = {mem[a].cls, 3'($urandom_range(0, 7))};
    cmd_time     = mem[a].t;
    jump_addr    = mem[a].j;
    alu_cond     = mem[a].cond;
  endtask

  // Instruction memory: answers a read request `lat` cycles after mem_rd_en.
  initial begin
    mem_pend = 1'b0;
    mem_cnt  = 0;
    mem_addr = '0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (reset) mem_pend = 1'b0;
      else if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt <= 0) begin
          present(mem_addr);
          mem_pend = 1'b0;
        end
      end else if (mem_rd_en) begin
        mem_addr = instr_ptr;
        if (lat == 0) present(mem_addr);
        else begin
          mem_pend = 1'b1;
          mem_cnt  = lat;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (qclk_run) qclk_val = qclk_val + 1;
  end

  // Strobe monitor: every execute strobe must match the next expected event.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      mon_n = int'(c_strobe) + int'(reg_write_en) + int'(qclk_load_en);
      if (mon_n > 0) begin
        checks++;
        mon_kind = c_strobe ? EV_STROBE : (reg_write_en ? EV_REG : EV_QCLK);
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe kind=%0d qclk=%0d at %0t", mon_kind, qclk_val, $time);
        end else begin
          mon_e = sb.pop_front();
          if (mon_n != 1 || mon_kind !== mon_e.kind ||
              (mon_e.chk_time && qclk_val !== mon_e.qclk)) begin
            failures++;
            $display("FAIL strobe_event got kind=%0d n=%0d qclk=%0d exp kind=%0d qclk=%0d",
                     mon_kind, mon_n, qclk_val, mon_e.kind, mon_e.qclk);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '{C_NOP, '0, '0, 1'b0};
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b0; sync_in = 1'b0; fproc_in = 1'b0; qclk_run = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid_edge(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (mem_rd_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic sb_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got=%0d exp=0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (outs_vec() !== 9'b0 || instr_ptr !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b ptr=%0h exp=0", outs_vec(), instr_ptr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_vec() !== 9'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0", outs_vec());
    end
  endtask

  task automatic test_reg_alu();
    bit ok;
    do_reset();
    clear_mem();
    mem[0] = '{C_REG_ALU, '0, '0, 1'b0};
    mem[1] = '{C_DONE, '0, '0, 1'b0};
    lat = 3;
    sb.push_back('{EV_REG, 1'b0, '0});
    pulse_start();
    @(negedge clk);
    checks++;
    if ({mem_rd_en, busy} !== 2'b11) begin
      failures++;
      $display("FAIL first_fetch got=%b exp=11", {mem_rd_en, busy});
    end
    @(negedge clk);
    checks++;
    if (mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rd_en_single got=%b exp=0", mem_rd_en);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (reg_write_en !== 1'b0) begin
      failures++;
      $display("FAIL early_reg_write got=%b exp=0", reg_write_en);
    end
    @(negedge clk);
    checks++;
    if (reg_write_en !== 1'b1 || instr_ptr !== 8'h00) begin
      failures++;
      $display("FAIL reg_write_exec got=%b ptr=%0h exp=1 ptr=0", reg_write_en, instr_ptr);
    end
    @(negedge clk);
    checks++;
    if (reg_write_en !== 1'b0 || instr_ptr !== 8'h01) begin
      failures++;
      $display("FAIL reg_write_after got=%b ptr=%0h exp=0 ptr=1", reg_write_en, instr_ptr);
    end
    wait_done(50, ok);
    checks++;
    if (!ok || busy !== 1'b0 || instr_ptr !== 8'h01) begin
      failures++;
      $display("FAIL reg_alu_done got=%b busy=%b ptr=%0h exp=1 busy=0 ptr=1", ok, busy, instr_ptr);
    end
    sb_drained("reg_alu");
  endtask

  task automatic run_pulse(input string name, input logic [TW-1:0] q0,
                           input bit run, input logic [TW-1:0] t);
    bit ok;
    do_reset();
    clear_mem();
    mem[0] = '{C_PULSE_I, t, '0, 1'b0};
    mem[1] = '{C_DONE, '0, '0, 1'b0};
    lat = 1;
    qclk_val = q0;
    qclk_run = run;
    pulse_start();
    wait_done(100, ok);
    qclk_run = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done got=0 exp=1", name);
    end
  endtask

  task automatic test_pulse_wait();
    sb.push_back('{EV_STROBE, 1'b1, 32'd100});
    run_pulse("pulse_100", 32'd90, 1'b1, 32'd100);
    sb_drained("pulse_100");
    sb.push_back('{EV_STROBE, 1'b1, 32'd5});
    run_pulse("pulse_wrap", 32'hFFFF_FFFE, 1'b1, 32'd5);
    sb_drained("pulse_wrap");
    sb.push_back('{EV_STROBE, 1'b1, 32'd50});
    run_pulse("pulse_now", 32'd50, 1'b0, 32'd50);
    sb_drained("pulse_now");
  endtask

  task automatic test_pulse_late();
    if (!LATE_MODE) sb.push_back('{EV_STROBE, 1'b1, 32'd20});
    run_pulse("pulse_late", 32'd20, 1'b0, 32'd10);
    checks++;
    if (late_err !== LATE_MODE) begin
      failures++;
      $display("FAIL late_err got=%b exp=%b", late_err, LATE_MODE);
    end
    sb_drained("pulse_late");
    mem[0] = '{C_DONE, '0, '0, 1'b0};
    pulse_start();
    @(negedge clk);
    checks++;
    if (late_err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL late_err_clear got=%b busy=%b exp=0 busy=1", late_err, busy);
    end
  endtask

  task automatic test_jump();
    bit found;
    logic [AW-1:0] exp_ptr;
    do_reset();
    clear_mem();
    mem[8'h00] = '{C_JUMP_COND_I, '0, 8'h40, 1'b1};
    mem[8'h40] = '{C_JUMP_COND_I, '0, 8'h10, 1'b0};
    mem[8'h41] = '{C_JUMP_I, '0, 8'hFF, 1'b0};
    mem[8'hFF] = '{C_NOP, '0, 8'h22, 1'b0};
    lat = 0;
    ptr_sb = '{8'h00, 8'h40, 8'h41, 8'hFF, 8'h00};
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (mem_rd_en === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      exp_ptr = ptr_sb.pop_front();
      checks++;
      if (!found || instr_ptr !== exp_ptr) begin
        failures++;
        $display("FAIL jump_trace_%0d got=%0h found=%b exp=%0h", k, instr_ptr, found, exp_ptr);
      end
    end
    sb_drained("jump");
  endtask

  task automatic test_wait_sync();
    bit ok;
    do_reset();
    clear_mem();
    mem[0] = '{C_WAIT_SYNC, '0, '0, 1'b0};
    mem[1] = '{C_DONE, '0, '0, 1'b0};
    lat = 1;
    pulse_start();
    wait_valid_edge(20, ok);
    #1 sync_in = 1'b1;
    @(posedge clk);
    #1 sync_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (!ok || sync_out_ready !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL sync_wait_%0d got=%b busy=%b exp=1 busy=1", i, sync_out_ready, busy);
      end
    end
    @(posedge clk);
    #1 sync_in = 1'b1;
    @(posedge clk);
    #1 sync_in = 1'b0;
    @(negedge clk);
    checks++;
    if (sync_out_ready !== 1'b0 || instr_ptr !== 8'h01) begin
      failures++;
      $display("FAIL sync_release got=%b ptr=%0h exp=0 ptr=1", sync_out_ready, instr_ptr);
    end
    wait_done(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL sync_done got=0 exp=1");
    end
  endtask

  task automatic test_wait_fproc();
    bit ok;
    do_reset();
    clear_mem();
    mem[0] = '{C_WAIT_FPROC, '0, '0, 1'b0};
    lat = 1;
    pulse_start();
    wait_valid_edge(20, ok);
    #1 fproc_in = 1'b1;
    @(posedge clk);
    #1 fproc_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (!ok || fproc_out_ready !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL fproc_wait_%0d got=%b busy=%b exp=1 busy=1", i, fproc_out_ready, busy);
      end
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (outs_vec() !== 9'b0 || instr_ptr !== '0) begin
      failures++;
      $display("FAIL fproc_async_reset got=%b ptr=%0h exp=0", outs_vec(), instr_ptr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs_vec() !== 9'b0) begin
      failures++;
      $display("FAIL fproc_idle got=%b exp=0", outs_vec());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    clear_mem();
    mem[0] = '{C_REG_WRITE_I, '0, '0, 1'b0};
    mem[1] = '{C_INC_QCLK, '0, '0, 1'b0};
    mem[2] = '{C_INC_QCLK_I, '0, '0, 1'b0};
    mem[3] = '{C_REG_I_ALU, '0, '0, 1'b0};
    mem[4] = '{C_NOP, '0, '0, 1'b0};
    mem[5] = '{C_REG_ALU, '0, '0, 1'b0};
    mem[6] = '{C_DONE, '0, '0, 1'b0};
    lat = 0;
    sb.push_back('{EV_REG, 1'b0, '0});
    sb.push_back('{EV_QCLK, 1'b0, '0});
    sb.push_back('{EV_QCLK, 1'b0, '0});
    sb.push_back('{EV_REG, 1'b0, '0});
    sb.push_back('{EV_REG, 1'b0, '0});
    pulse_start();
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(50, ok);
    checks++;
    if (!ok || instr_ptr !== 8'h06) begin
      failures++;
      $display("FAIL b2b_done got=%b ptr=%0h exp=1 ptr=6", ok, instr_ptr);
    end
    sb_drained("b2b");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_rd_valid = 1'b0; opcode = '0;
    cmd_time = '0; jump_addr = '0; qclk_val = '0; alu_cond = 1'b0;
    sync_in = 1'b0; fproc_in = 1'b0;
    clear_mem();
    test_reset();
    test_reg_alu();
    test_pulse_wait();
    test_pulse_late();
    test_jump();
    test_wait_sync();
    test_wait_fproc();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: instruction pointer width.
REQ-002 SHALL have parameter TIME_WIDTH, default 32: qclk and command-time width.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin execution at address 0; sampled only in IDLE or DONE.
REQ-006 SHALL have ports mem_rd_en (output, 1) and mem_rd_valid (input, 1): instruction read request and read-data-valid.
REQ-007 SHALL have ports opcode (input, 8), cmd_time (input, TIME_WIDTH) and jump_addr (input, ADDR_WIDTH): fields of the fetched word, valid with mem_rd_valid.
REQ-008 SHALL have ports qclk_val (input, TIME_WIDTH) and alu_cond (input, 1): current qclk and branch-compare result.
REQ-009 SHALL have ports sync_in and fproc_in (inputs, 1 each): sync and fproc completion strobes.
REQ-010 SHALL have output port instr_ptr, ADDR_WIDTH: current fetch address.
REQ-011 SHALL have outputs c_strobe, reg_write_en and qclk_load_en, 1 each: single-cycle execute pulses.
REQ-012 SHALL have outputs sync_out_ready, fproc_out_ready, busy, done and late_err, 1 each.

Function
REQ-013 SHALL implement states IDLE, FETCH, EXEC, WAIT_TIME, WAIT_SYNC, WAIT_FPROC and DONE.
REQ-014 IDLE/DONE: start=1 SHALL clear instr_ptr to 0 and enter FETCH; start in any other state SHALL be ignored.
REQ-015 FETCH: mem_rd_en SHALL be 1 on the first FETCH cycle only; the FSM SHALL hold until mem_rd_valid=1, latch opcode, cmd_time and jump_addr, and enter EXEC next cycle.
REQ-016 EXEC SHALL decode opcode[7:3] using the instruction-parameter class codes and SHALL last exactly one cycle.
REQ-017 PULSE_I: d = cmd_time - qclk_val (mod 2^TIME_WIDTH, signed). d=0: assert c_strobe in EXEC. d>0: enter WAIT_TIME. d<0: late pulse, REQ-030/031.
REQ-018 WAIT_TIME SHALL assert c_strobe for exactly one cycle when qclk_val equals latched cmd_time, then advance.
REQ-019 REG_WRITE_I, REG_I_ALU, REG_ALU SHALL assert reg_write_en for the EXEC cycle.
REQ-020 INC_QCLK, INC_QCLK_I SHALL assert qclk_load_en for the EXEC cycle.
REQ-021 JUMP_I SHALL load instr_ptr with jump_addr; JUMP_COND_I SHALL do so only if alu_cond=1, else advance.
REQ-022 WAIT_SYNC and WAIT_FPROC classes SHALL enter their wait states, holding sync_out_ready/fproc_out_ready at 1 until sync_in/fproc_in=1, then advance.
REQ-023 A strobe present in the same cycle the wait state is entered SHALL NOT be counted; only strobes sampled inside the wait state complete it.
REQ-024 DONE class SHALL enter DONE; unrecognised classes SHALL advance as no-ops.
REQ-025 Advance SHALL mean instr_ptr+1 with wrap from 2^ADDR_WIDTH-1 to 0, then FETCH.
REQ-026 busy SHALL be 1 in all states except IDLE and DONE; done SHALL be 1 only in DONE.
REQ-027 All execute pulses SHALL be mutually exclusive and at most one cycle per instruction.

Reset
REQ-028 reset=1 SHALL force IDLE immediately, from any state including mid-wait.
REQ-029 reset SHALL clear instr_ptr, late_err and all outputs to 0, and discard any latched instruction.

Configuration
REQ-030 Macro INSTR_SEQ_LATE_CHECK_EN defined: a late PULSE_I SHALL set sticky late_err (cleared only by reset or start) and SHALL NOT assert c_strobe.
REQ-031 Macro undefined: late_err SHALL be constant 0 and a late PULSE_I SHALL assert c_strobe in EXEC.

Verification
REQ-032 Reset, start; mem_rd_valid 3 cycles after mem_rd_en, REG_ALU -> reg_write_en one cycle, instr_ptr 0->1.
REQ-033 PULSE_I, cmd_time=100, qclk_val counting from 90 -> c_strobe exactly in the cycle qclk_val=100.
REQ-034 PULSE_I, cmd_time=5, qclk_val=0xFFFFFFFE -> waits across wrap, c_strobe when qclk_val=5.
REQ-035 PULSE_I, cmd_time=10, qclk_val=20 -> LATE_CHECK_EN: late_err=1, no c_strobe; else c_strobe, late_err=0.
REQ-036 JUMP_COND_I, jump_addr=0x40: alu_cond=1 -> instr_ptr=0x40; alu_cond=0 -> instr_ptr+1; instr_ptr=0xFF advance -> 0x00.
REQ-037 WAIT_FPROC, fproc_in high on entry cycle then low, reset pulsed 5 cycles later -> fproc_out_ready=1 until reset, then IDLE with all outputs 0.
